// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer
//
// Multi-cycle shift-add multiply controller for the KGP-RISC core. A request
// accepted in IDLE is turned into sign flags plus operand magnitudes. The
// product is then built one multiplier bit per cycle. A final FIX cycle
// restores the sign and writes the HI/LO result registers together with an
// overflow flag for the high word.
//
// Ports
//   clk        core clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   start      multiply request, only looked at while idle
//   signed_op  1 = two's-complement multiply, 0 = unsigned (sampled with start)
//   op_a       multiplicand (sampled with start)
//   op_b       multiplier (sampled with start)
//   busy       an operation is in progress
//   stall      hold PC / suppress write-back until the product is ready
//   done       one-cycle pulse: hi/lo/mult_flag were just updated
//   hi, lo     upper / lower words of the 2*WIDTH-bit product
//   mult_flag  product does not fit in WIDTH bits
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_flag
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]         state_q,  state_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               signed_q, signed_d;
    logic               neg_q,    neg_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic               flag_q,   flag_d;
    logic               done_q,   done_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;

    // Operand preparation. The magnitude of the most negative value is kept
    // as the unsigned 2^(WIDTH-1), which still fits in WIDTH bits.
    always_comb begin
        sign_a = signed_op & op_a[WIDTH-1];
        sign_b = signed_op & op_b[WIDTH-1];
        mag_a  = sign_a ? -op_a : op_a;
        mag_b  = sign_b ? -op_b : op_b;
    end

    // One iteration of the shift-add datapath. The sum is WIDTH+1 bits so that
    // the carry out of the upper half is shifted back into the accumulator.
    always_comb begin
        addend  = mplier_q[0] ? mcand_q : '0;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        product = neg_q ? -acc_q : acc_q;
    end

    // Next-state logic: IDLE loads the operands, RUN iterates WIDTH times,
    // and FIX applies the sign and publishes the result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        signed_d = signed_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        flag_d   = flag_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    signed_d = signed_op;
                    neg_d    = sign_a ^ sign_b;
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_d    = product[2*WIDTH-1:WIDTH];
                lo_d    = product[WIDTH-1:0];
                // Signed results overflow when the high word is not a pure
                // sign extension of the low word.
                flag_d  = signed_q ? (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}})
                                   : (product[2*WIDTH-1:WIDTH] != '0);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with immediate clear on reset; an operation in flight
    // is simply discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            signed_q <= 1'b0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            flag_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            signed_q <= signed_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            flag_q   <= flag_d;
            done_q   <= done_d;
        end
    end

    // Stall covers the request cycle itself so the core freezes before the
    // first edge, and drops in the done cycle so the instruction can retire.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        stall     = busy | (start & (state_q == ST_IDLE));
        done      = done_q;
        hi        = hi_q;
        lo        = lo_q;
        mult_flag = flag_q;
    end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle multiply controller for the KGP-RISC core. It accepts a multiply request from decode, runs a shift-add datapath one bit per cycle, and writes the 2×WIDTH-bit product into the HI/LO result registers. It raises a stall that freezes the PC and register write-back until the product is ready, then reports an overflow flag for the high word. It sits beside the ALU and is driven by the same decode that produces Branch/regWrite/MemRead/MemWrite.

## Interface
- WIDTH, 32, operand width; product is 2×WIDTH
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  multiply request; sampled only in IDLE
- signed_op  in  1  1 = two's-complement multiply, 0 = unsigned; sampled with start
- op_a  in  WIDTH  multiplicand; sampled with start
- op_b  in  WIDTH  multiplier; sampled with start
- busy  out  1  operation in progress (state ≠ IDLE)
- stall  out  1  hold PC / suppress write-back; combinational = busy | (start & IDLE)
- done  out  1  one-cycle pulse: hi/lo/mult_flag just updated
- hi  out  WIDTH  upper product word
- lo  out  WIDTH  lower product word
- mult_flag  out  1  product does not fit in WIDTH bits

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on start=1, latch sign_a/sign_b (MSBs when signed_op=1, else 0), magnitudes |op_a|, |op_b| (two's-complement negate when sign bit set), clear 2×WIDTH accumulator, load counter = WIDTH, go RUN.
- RUN: each cycle, if multiplier LSB = 1 add multiplicand to accumulator upper half; shift {carry, accumulator} right one; decrement counter. On counter reaching 1 (last iteration), go FIX.
- FIX: product = accumulator, negated (2×WIDTH two's complement) if signed_op and sign_a ≠ sign_b; write hi = product[2W-1:W], lo = product[W-1:0]; set done; go IDLE.
- Magnitude of 0x8000_0000 is treated as unsigned 2^31; carry bit makes the adder WIDTH+1 bits; no truncation anywhere in the path.
- mult_flag: unsigned → hi ≠ 0; signed → hi ≠ {WIDTH{lo[W-1]}}. Updated only on the FIX edge.
- Fixed latency: no early exit for zero or small operands.
- hi, lo, mult_flag hold until the next FIX edge or reset.
- start while busy: ignored; no queueing, no effect on current operation.

## Timing
- Reset (async, immediate): state = IDLE, hi = 0, lo = 0, mult_flag = 0, done = 0, busy = 0, counter/accumulator = 0. stall follows start combinationally even during release.
- Edge E0: start sampled in IDLE. Edges E1..EWIDTH: RUN iterations. Edge EWIDTH+1: FIX writes hi/lo/mult_flag, done = 1.
- Latency: result visible and done = 1 in the cycle after edge E(WIDTH+1) (34 edges from E0 inclusive for WIDTH = 32); done low again after the next edge.
- stall = 1 from the cycle start is presented through the FIX cycle; 0 in the done cycle, so the core retires the instruction and reads hi/lo then.
- Back-to-back: in the done cycle state is IDLE; a new start is accepted on that edge, hi/lo keep the previous result until its own FIX edge.
- Reset mid-operation: operation discarded, no done pulse, outputs at reset values; next start after rst deasserts begins cleanly.

## Test plan
- Unsigned 7 × 6, start pulse at E0 → busy/stall high, done single pulse at E33 cycle, hi = 0x00000000, lo = 0x0000002A, mult_flag = 0.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001, mult_flag = 1.
- Signed −3 × 5 (0xFFFFFFFD, 0x00000005) → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1, mult_flag = 0; signed 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0x00000000, mult_flag = 1.
- start held high with different operands during RUN → ignored, first result unchanged; start asserted in done cycle (9 × 9 unsigned) → accepted, previous result held 33 cycles, then lo = 0x51.
- Assert rst at cycle 10 of a 0x1234 × 0x10 operation → immediate busy = 0, hi = lo = 0, no done pulse; new 2 × 3 after release → lo = 6 at expected latency.
